// File: rtl/mem_access_controller_if.sv
// rtl/mem_access_controller_if.sv - request and word-memory signal bundle for mem_access_controller
interface mem_access_controller_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] loadData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    modport master (
        input  start, op, addr, storeData, readData,
        output busy, done, fault, loadData, memRead, memWrite, address, writeData
    );

    modport slave (
        output start, op, addr, storeData, readData,
        input  busy, done, fault, loadData, memRead, memWrite, address, writeData
    );
endinterface

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - byte/half/word load-store engine over a word-only memory
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_controller #(
    parameter logic [31:0] MEM_LO = 32'h7FFFFBFC,
    parameter logic [31:0] MEM_HI = 32'h7FFFFFFF
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_access_controller_if.master bus
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] store_q;
    logic [31:0] load_q;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;

    logic        misaligned;
    logic        out_of_range;
    logic        bad_req;
    logic        sub_store;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        misaligned = 1'b0;
        case (bus.op)
            OP_LW, OP_SW:         misaligned = |bus.addr[1:0];
            OP_LH, OP_LHU, OP_SH: misaligned = bus.addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (bus.addr < MEM_LO) || (bus.addr > MEM_HI);
    assign bad_req      = misaligned || out_of_range;
    assign sub_store    = (op_q == OP_SH) || (op_q == OP_SB);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bad_req)
                        state_next = S_FAULT;
                    else if (bus.op == OP_SW)
                        state_next = S_WRITE;
                    else
                        state_next = S_READ;
                end
            end
            S_READ:  state_next = sub_store ? S_WRITE : S_DONE;
            S_WRITE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_FAULT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Little-endian lane pick from the word returned during READ
    always_comb begin
        byte_lane = 8'h00;
        case (lane_q)
            2'd0: byte_lane = bus.readData[7:0];
            2'd1: byte_lane = bus.readData[15:8];
            2'd2: byte_lane = bus.readData[23:16];
            2'd3: byte_lane = bus.readData[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = lane_q[1] ? bus.readData[31:16] : bus.readData[15:0];
    end

    always_comb begin
        load_ext = bus.readData;
        case (op_q)
            OP_LB:   load_ext = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_ext = {24'h0, byte_lane};
            OP_LH:   load_ext = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_ext = {16'h0, half_lane};
            default: load_ext = bus.readData;
        endcase
    end

    always_comb begin
        merged = bus.readData;
        if (op_q == OP_SH) begin
            if (lane_q[1])
                merged = {store_q, bus.readData[15:0]};
            else
                merged = {bus.readData[31:16], store_q};
        end else begin
            case (lane_q)
                2'd0: merged = {bus.readData[31:8], store_q[7:0]};
                2'd1: merged = {bus.readData[31:16], store_q[7:0], bus.readData[7:0]};
                2'd2: merged = {bus.readData[31:24], store_q[7:0], bus.readData[15:0]};
                2'd3: merged = {store_q[7:0], bus.readData[23:0]};
                default: merged = bus.readData;
            endcase
        end
    end

    // address/writeData only move on an accepted request or at the end of READ
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= 3'd0;
            lane_q  <= 2'd0;
            store_q <= 16'h0;
            load_q  <= 32'h0;
            addr_r  <= 32'h0;
            wdata_r <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        lane_q  <= bus.addr[1:0];
                        store_q <= bus.storeData[15:0];
                        if (!bad_req) begin
                            addr_r <= {bus.addr[31:2], 2'b00};
                            if (bus.op == OP_SW)
                                wdata_r <= bus.storeData;
                        end
                    end
                end
                S_READ: begin
                    if (sub_store)
                        wdata_r <= merged;
                    else
                        load_q <= load_ext;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.fault     = (state == S_FAULT);
    assign bus.memRead   = (state == S_READ);
    assign bus.memWrite  = (state == S_WRITE);
    assign bus.loadData  = load_q;
    assign bus.address   = addr_r;
    assign bus.writeData = wdata_r;
endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - self-checking bench with a cycle-schedule reference model
module tb_mem_access_controller;
    localparam logic [31:0] LO = 32'h7FFFFBFC;
    localparam logic [31:0] HI = 32'h7FFFFFFF;
    localparam int NW = 257;
    localparam int NC = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mem_access_controller_if bus ();

    mem_access_controller #(.MEM_LO(LO), .MEM_HI(HI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    bit chk_en = 1'b0;

    logic [31:0] emem [0:NW-1];
    logic [31:0] mmem [0:NW-1];

    bit          exp_busy [0:NC-1];
    bit          exp_done [0:NC-1];
    bit          exp_flt  [0:NC-1];
    bit          exp_rd   [0:NC-1];
    bit          exp_wr   [0:NC-1];
    bit          exp_ldv  [0:NC-1];
    logic [31:0] exp_ldd  [0:NC-1];
    logic [31:0] exp_addr [0:NC-1];
    logic [31:0] exp_wd   [0:NC-1];
    logic [31:0] cur_load = 32'h0;

    function automatic int widx(input logic [31:0] a);
        logic [31:0] d;
        d = (a - LO) >> 2;
        return int'(d);
    endfunction

    always_comb begin
        bus.readData = 32'h0;
        if (bus.address >= LO && bus.address <= HI)
            bus.readData = emem[widx(bus.address)];
    end

    always @(negedge clk)
        if (bus.memWrite && bus.address >= LO && bus.address <= HI)
            emem[widx(bus.address)] = bus.writeData;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset && cyc < NC) begin
            if (exp_ldv[cyc]) cur_load = exp_ldd[cyc];
            check("busy",     {31'h0, bus.busy},     {31'h0, exp_busy[cyc]});
            check("done",     {31'h0, bus.done},     {31'h0, exp_done[cyc]});
            check("fault",    {31'h0, bus.fault},    {31'h0, exp_flt[cyc]});
            check("memRead",  {31'h0, bus.memRead},  {31'h0, exp_rd[cyc]});
            check("memWrite", {31'h0, bus.memWrite}, {31'h0, exp_wr[cyc]});
            check("loadData", bus.loadData, cur_load);
            if (exp_rd[cyc] || exp_wr[cyc]) check("address", bus.address, exp_addr[cyc]);
            if (exp_wr[cyc]) check("writeData", bus.writeData, exp_wd[cyc]);
        end
    end

    // Reference: decides legality, latency and memory effect of one request, then
    // writes the per-cycle expectations relative to the current cycle c.
    task automatic model_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                             output int lat);
        int c;
        int sh;
        bit bad;
        logic [31:0] w, v, mask, wa;
        c = cyc;
        bad = (a < LO) || (a > HI);
        if ((o == 3'd0 || o == 3'd5) && (a % 4) != 0) bad = 1;
        if ((o == 3'd1 || o == 3'd2 || o == 3'd6) && (a % 2) != 0) bad = 1;
        wa = a - (a % 4);
        if (bad) begin
            lat = 1;
            exp_busy[c+1] = 1;
            exp_flt[c+1]  = 1;
            return;
        end
        w = mmem[widx(a)];
        if (o <= 3'd4) begin
            lat = 2;
            if (o == 3'd3 || o == 3'd4) begin
                sh = 8 * int'(a % 4);
                v = (w >> sh) & 32'hFF;
                if (o == 3'd3 && v >= 128) v = v + 32'hFFFFFF00;
            end else if (o == 3'd1 || o == 3'd2) begin
                sh = 16 * int'((a / 2) % 2);
                v = (w >> sh) & 32'hFFFF;
                if (o == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
            end else begin
                v = w;
            end
            exp_rd[c+1] = 1; exp_addr[c+1] = wa;
            exp_ldv[c+2] = 1; exp_ldd[c+2] = v;
        end else if (o == 3'd5) begin
            lat = 2;
            exp_wr[c+1] = 1; exp_addr[c+1] = wa; exp_wd[c+1] = d;
            mmem[widx(a)] = d;
        end else begin
            lat = 3;
            if (o == 3'd7) begin
                sh = 8 * int'(a % 4);
                mask = 32'hFF << sh;
                v = (w & ~mask) | ((d & 32'hFF) << sh);
            end else begin
                sh = 16 * int'((a / 2) % 2);
                mask = 32'hFFFF << sh;
                v = (w & ~mask) | ((d & 32'hFFFF) << sh);
            end
            exp_rd[c+1] = 1; exp_addr[c+1] = wa;
            exp_wr[c+2] = 1; exp_addr[c+2] = wa; exp_wd[c+2] = v;
            mmem[widx(a)] = v;
        end
        for (int k = 1; k <= lat; k++) exp_busy[c+k] = 1;
        exp_done[c+lat] = 1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        int lat;
        model_req(o, a, d, lat);
        bus.start = 1'b1; bus.op = o; bus.addr = a; bus.storeData = d;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (lat) @(negedge clk);
    endtask

    initial begin
        bit wr_seen;
        int lat;
        bit img_ok;
        for (int i = 0; i < NW; i++) begin emem[i] = 32'h0; mmem[i] = 32'h0; end
        bus.start = 1'b0; bus.op = 3'd0; bus.addr = 32'h0; bus.storeData = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_busy",  {31'h0, bus.busy},     32'h0);
        check("rst_done",  {31'h0, bus.done},     32'h0);
        check("rst_fault", {31'h0, bus.fault},    32'h0);
        check("rst_rd",    {31'h0, bus.memRead},  32'h0);
        check("rst_wr",    {31'h0, bus.memWrite}, 32'h0);
        check("rst_load",  bus.loadData,  32'h0);
        check("rst_addr",  bus.address,   32'h0);
        check("rst_wdata", bus.writeData, 32'h0);
        reset = 1'b0;

        // Reset during the READ of an SB must abort before any write
        emem[widx(32'h7FFFFF00)] = 32'h12345678;
        mmem[widx(32'h7FFFFF00)] = 32'h12345678;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd7; bus.addr = 32'h7FFFFF00; bus.storeData = 32'hAA;
        @(negedge clk);
        bus.start = 1'b0;
        check("midrst_in_read", {31'h0, bus.memRead}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy",  {31'h0, bus.busy},     32'h0);
        check("midrst_rd",    {31'h0, bus.memRead},  32'h0);
        check("midrst_wr",    {31'h0, bus.memWrite}, 32'h0);
        check("midrst_addr",  bus.address,   32'h0);
        check("midrst_wdata", bus.writeData, 32'h0);
        wr_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.memWrite) wr_seen = 1;
        end
        reset = 1'b0;
        check("midrst_no_write", {31'h0, wr_seen}, 32'h0);
        check("midrst_word", emem[widx(32'h7FFFFF00)], 32'h12345678);
        chk_en = 1'b1;
        @(negedge clk);

        issue(3'd5, 32'h7FFFFF00, 32'hDEADBEEF);
        issue(3'd0, 32'h7FFFFF00, 32'h0);
        check("lw_deadbeef", bus.loadData, 32'hDEADBEEF);

        issue(3'd5, 32'h7FFFFF10, 32'h80FF7F01);
        issue(3'd3, 32'h7FFFFF13, 32'h0); check("lb_p3",  bus.loadData, 32'hFFFFFF80);
        issue(3'd4, 32'h7FFFFF13, 32'h0); check("lbu_p3", bus.loadData, 32'h00000080);
        issue(3'd3, 32'h7FFFFF11, 32'h0); check("lb_p1",  bus.loadData, 32'h0000007F);
        issue(3'd3, 32'h7FFFFF10, 32'h0); check("lb_p0",  bus.loadData, 32'h00000001);
        issue(3'd1, 32'h7FFFFF12, 32'h0); check("lh_p2",  bus.loadData, 32'hFFFF80FF);
        issue(3'd2, 32'h7FFFFF12, 32'h0); check("lhu_p2", bus.loadData, 32'h000080FF);
        issue(3'd1, 32'h7FFFFF10, 32'h0); check("lh_p0",  bus.loadData, 32'h00007F01);

        issue(3'd5, 32'h7FFFFF20, 32'h11223344);
        issue(3'd7, 32'h7FFFFF21, 32'h000000AA);
        check("sb_merge", emem[widx(32'h7FFFFF20)], 32'h1122AA44);
        issue(3'd6, 32'h7FFFFF22, 32'h0000BEEF);
        check("sh_merge", emem[widx(32'h7FFFFF20)], 32'hBEEFAA44);
        issue(3'd0, 32'h7FFFFF20, 32'h0);
        check("lw_merged", bus.loadData, 32'hBEEFAA44);

        issue(3'd0, 32'h7FFFFF02, 32'h0);
        issue(3'd6, 32'h7FFFFF01, 32'h1234);
        issue(3'd5, 32'h00000000, 32'hFFFFFFFF);
        check("fault_load_kept", bus.loadData, 32'hBEEFAA44);

        issue(3'd5, 32'h7FFFFBFC, 32'h0A0B0C0D);
        issue(3'd0, 32'h7FFFFBFC, 32'h0);
        check("lw_lo_edge", bus.loadData, 32'h0A0B0C0D);
        issue(3'd0, 32'h7FFFFBF8, 32'h0);
        issue(3'd7, 32'h7FFFFFFF, 32'h00000099);
        check("sb_hi_edge", emem[widx(32'h7FFFFFFC)], 32'h99000000);
        issue(3'd3, 32'h7FFFFFFF, 32'h0);
        check("lb_hi_edge", bus.loadData, 32'hFFFFFF99);
        issue(3'd0, 32'h80000000, 32'h0);
        issue(3'd2, 32'h7FFFFFFE, 32'h0);
        check("lhu_hi_edge", bus.loadData, 32'h00009900);

        // start pulses during READ/WRITE/DONE of an SB are dropped, not queued
        model_req(3'd7, 32'h7FFFFF30, 32'h0000005A, lat);
        bus.start = 1'b1; bus.op = 3'd7; bus.addr = 32'h7FFFFF30; bus.storeData = 32'h5A;
        @(negedge clk);
        bus.op = 3'd5; bus.addr = 32'h7FFFFF40; bus.storeData = 32'h55555555;
        repeat (lat) @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_sb_word", emem[widx(32'h7FFFFF30)], 32'h0000005A);
        check("busy_sw_dropped", emem[widx(32'h7FFFFF40)], 32'h0);

        img_ok = 1;
        for (int i = 0; i < NW; i++) if (emem[i] !== mmem[i]) img_ok = 0;
        check("mem_image", {31'h0, img_ok}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
